// File: rtl/serial_cmp32_if.sv
// Handshake and operand/result bundle for the bit-serial 32-bit comparator.
// master drives the request side, slave (the comparator) drives status and result.
interface serial_cmp32_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        busy;
  logic        done;
  logic        lt;
  logic        eq;
  logic        gt;
  logic [31:0] res;

  modport master (
    output start, a, b, sgn,
    input  busy, done, lt, eq, gt, res
  );

  modport slave (
    input  start, a, b, sgn,
    output busy, done, lt, eq, gt, res
  );
endinterface

// File: rtl/serial_cmp32.sv
// Bit-serial 32-bit magnitude comparator, signed or unsigned, scanning MSB first
// with early termination on the first differing bit.
module serial_cmp32 (
  input  logic           clk,
  input  logic           rst,
  serial_cmp32_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic        sgn_reg, sgn_next;
  logic [4:0]  idx_reg, idx_next;
  logic        lt_reg, lt_next;
  logic        eq_reg, eq_next;
  logic        gt_reg, gt_next;
  logic        busy_reg, busy_next;

  logic [31:0] diff_vec;
  logic [31:0] lt_vec;
  logic        bit_diff;
  logic        bit_lt;

  // Per-bit "A below B" terms; the sign bit inverts its sense for signed compares.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign diff_vec[gi] = a_reg[gi] ^ b_reg[gi];
      if (gi == 31) begin : g_msb
        assign lt_vec[gi] = sgn_reg ? (a_reg[gi] & ~b_reg[gi])
                                    : (~a_reg[gi] & b_reg[gi]);
      end else begin : g_lsb
        assign lt_vec[gi] = ~a_reg[gi] & b_reg[gi];
      end
    end
  endgenerate

  assign bit_diff = diff_vec[idx_reg];
  assign bit_lt   = lt_vec[idx_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      sgn_reg   <= 1'b0;
      idx_reg   <= 5'd31;
      lt_reg    <= 1'b0;
      eq_reg    <= 1'b0;
      gt_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sgn_reg   <= sgn_next;
      idx_reg   <= idx_next;
      lt_reg    <= lt_next;
      eq_reg    <= eq_next;
      gt_reg    <= gt_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sgn_next   = sgn_reg;
    idx_next   = idx_reg;
    lt_next    = lt_reg;
    eq_next    = eq_reg;
    gt_next    = gt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.a;
          b_next     = bus.b;
          sgn_next   = bus.sgn;
          idx_next   = 5'd31;
          state_next = SCAN;
        end
      end
      SCAN: begin
        // Old flags stay visible until the new result is written here.
        if (bit_diff) begin
          lt_next    = bit_lt;
          gt_next    = ~bit_lt;
          eq_next    = 1'b0;
          state_next = DONE;
        end else if (idx_reg == 5'd0) begin
          lt_next    = 1'b0;
          gt_next    = 1'b0;
          eq_next    = 1'b1;
          state_next = DONE;
        end else begin
          idx_next = idx_reg - 5'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign bus.busy = busy_reg;
  assign bus.done = (state_reg == DONE);
  assign bus.lt   = lt_reg;
  assign bus.eq   = eq_reg;
  assign bus.gt   = gt_reg;
  assign bus.res  = {31'd0, lt_reg};

endmodule

// File: tb/tb_serial_cmp32.sv
// Self-checking bench for serial_cmp32: directed corner cases, reset abort,
// ignored start while busy, and a long back-to-back random run against a model.
module tb_serial_cmp32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [2:0] held_flags;   // expected {lt,eq,gt} currently presented by the DUT

  serial_cmp32_if bus ();

  serial_cmp32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain relational compare, independent of any bit scanning.
  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic l, e;
    l = sgn ? ($signed(a) < $signed(b)) : (a < b);
    e = (a == b);
    return {l, e, ~l & ~e};
  endfunction

  // Cycles from the accepting edge to the edge that raises done.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    int k;
    k = -1;
    for (int i = 0; i < 32; i++)
      if (a[i] != b[i]) k = i;
    return (k < 0) ? 32 : 32 - k;
  endfunction

  function automatic logic [2:0] obs_flags();
    return {bus.lt, bus.eq, bus.gt};
  endfunction

  // Called one step after a rising edge with the DUT idle; returns one step
  // after the edge that leaves DONE.
  task automatic run_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input bit poke);
    logic [2:0] exp;
    int         lat;
    int         n;
    logic       got_done;
    exp = ref_flags(a, b, sgn);
    lat = ref_lat(a, b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sgn   = sgn;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.sgn   = ~sgn;
    n = 0;
    got_done = 1'b0;
    check({tag, " busy_rise"}, {31'd0, bus.busy}, 32'd1);
    while (!got_done && n < 40) begin
      if (poke && n == 2) bus.start = 1'b1;
      if (poke && n == 3) bus.start = 1'b0;
      check({tag, " flags_held"}, {29'd0, obs_flags()}, {29'd0, held_flags});
      @(posedge clk); #1;
      n++;
      got_done = bus.done;
      check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    end
    bus.start = 1'b0;
    check({tag, " latency"}, n, lat);
    check({tag, " flags"}, {29'd0, obs_flags()}, {29'd0, exp});
    check({tag, " res"}, bus.res, {31'd0, exp[2]});
    held_flags = exp;
    $display("CMP %s a=%h b=%h sgn=%0d lt=%0b eq=%0b gt=%0b res=%0h cycles=%0d",
             tag, a, b, sgn, bus.lt, bus.eq, bus.gt, bus.res, n);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, " busy_fall"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " done"}, {31'd0, bus.done}, 32'd0);
    check({tag, " flags"}, {29'd0, obs_flags()}, 32'd0);
    check({tag, " res"}, bus.res, 32'd0);
  endtask

  initial begin
    int         n;
    int         dones;
    int         r;
    logic [31:0] va, vb;
    logic        vs;
    logic [2:0]  exp;
    logic        got_done;

    checks = 0;
    errors = 0;
    held_flags = 3'b000;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.sgn = 1'b0;
    #1;
    check_all_zero("reset_state");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmp("unsigned_msb", 32'h00000001, 32'h80000000, 1'b0, 1'b0);
    run_cmp("signed_msb",   32'h00000001, 32'h80000000, 1'b1, 1'b0);
    run_cmp("equal",        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
    run_cmp("signed_lsb",   32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("flags_hold_idle", {29'd0, obs_flags()}, {29'd0, held_flags});

    // Abort a compare with reset partway through the scan.
    bus.start = 1'b1;
    bus.a = 32'd5;
    bus.b = 32'd9;
    bus.sgn = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("reset_abort");
    held_flags = 3'b000;
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    check("no_done_after_reset", dones, 0);
    check_all_zero("post_reset_idle");

    // A start pulse mid-scan must not disturb the running compare.
    run_cmp("ignored_start", 32'd5, 32'd9, 1'b0, 1'b1);
    run_cmp("ignored_start_signed", 32'd9, 32'd5, 1'b1, 1'b1);

    // Start held high: every compare is followed by exactly one idle cycle.
    bus.start = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      va = $urandom;
      r  = $urandom_range(0, 31);
      if (r == 0)      vb = va;
      else if (r == 1) vb = va ^ (32'd1 << $urandom_range(0, 31));
      else             vb = $urandom;
      vs = 1'($urandom_range(0, 1));
      bus.a = va;
      bus.b = vb;
      bus.sgn = vs;
      exp = ref_flags(va, vb, vs);
      n = 0;
      got_done = 1'b0;
      while (!got_done && n < 40) begin
        @(posedge clk); #1;
        n++;
        got_done = bus.done;
      end
      check("b2b latency", n, ref_lat(va, vb) + 1);
      check("b2b flags", {29'd0, obs_flags()}, {29'd0, exp});
      check("b2b res", bus.res, {31'd0, exp[2]});
      $display("B2B %0d a=%h b=%h sgn=%0d lt=%0b eq=%0b gt=%0b cycles=%0d",
               i, va, vb, vs, bus.lt, bus.eq, bus.gt, n);
      @(posedge clk); #1;
      check("b2b idle_gap", {30'd0, bus.busy, bus.done}, 32'd0);
      if (n >= 40) break;
    end
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("final_idle", {31'd0, bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
